// File: rtl/mold_msg_seg_if.sv
// Beat-in / segment-out bundle for mold_msg_seg. Building with MSG_CNT_EN adds msg_cnt_o.
interface mold_msg_seg_if #(
  parameter int DATA_W = 64,
  parameter int LEN_W  = 4
`ifdef MSG_CNT_EN
  , parameter int MSG_LEN_W = 16
`endif
);
  localparam int OFF_W = $clog2(DATA_W / 8);

  logic              valid_i;
  logic              ready_o;
  logic              start_i;
  logic              last_i;
  logic [LEN_W-1:0]  last_len_i;
  logic [DATA_W-1:0] data_i;
  logic              valid_o;
  logic [OFF_W-1:0]  seg_off_o;
  logic [LEN_W-1:0]  seg_len_o;
  logic [DATA_W-1:0] seg_data_o;
  logic              msg_start_o;
  logic              msg_end_o;
  logic              err_o;

`ifdef MSG_CNT_EN
  logic [MSG_LEN_W-1:0] msg_cnt_o;

  modport master (
    output valid_i, start_i, last_i, last_len_i, data_i,
    input  ready_o, valid_o, seg_off_o, seg_len_o, seg_data_o, msg_start_o, msg_end_o, err_o,
    input  msg_cnt_o
  );
  modport slave (
    input  valid_i, start_i, last_i, last_len_i, data_i,
    output ready_o, valid_o, seg_off_o, seg_len_o, seg_data_o, msg_start_o, msg_end_o, err_o,
    output msg_cnt_o
  );
`else
  modport master (
    output valid_i, start_i, last_i, last_len_i, data_i,
    input  ready_o, valid_o, seg_off_o, seg_len_o, seg_data_o, msg_start_o, msg_end_o, err_o
  );
  modport slave (
    input  valid_i, start_i, last_i, last_len_i, data_i,
    output ready_o, valid_o, seg_off_o, seg_len_o, seg_data_o, msg_start_o, msg_end_o, err_o
  );
`endif
endinterface

// File: rtl/mold_msg_seg.sv
// Splits a MoldUDP64 message block into per-message byte segments, one segment per pass.
// Optional feature macro MSG_CNT_EN adds a saturating per-packet message counter (msg_cnt_o).
module mold_msg_seg #(
  parameter int DATA_W    = 64,
  parameter int LEN_W     = 4,
  parameter int MSG_LEN_W = 16,
  parameter int FIRST_OFF = 4
) (
  input  logic          clk,
  input  logic          nreset,
  mold_msg_seg_if.slave bus
);
  localparam int KEEP_W = DATA_W / 8;
  localparam int OFF_W  = $clog2(KEEP_W);

  typedef enum logic [1:0] {S_IDLE, S_LEN, S_LEN_LO, S_PAY} state_t;

  state_t               r_state, w_st;
  logic [LEN_W-1:0]     r_off, w_noff, w_p, w_e, w_avail, w_n;
  logic [MSG_LEN_W-1:0] r_rem, w_rem;
  logic [7:0]           r_hi, w_nhi;
  logic                 r_pend, w_first;
  logic                 r_hold, w_nhold;
  logic                 w_fresh, w_ready, w_emit, w_err, w_mstart, w_mend, w_pay, w_parsed;
  logic [OFF_W-1:0]     w_seg_off;
  logic [LEN_W-1:0]     w_seg_len;

  logic                 r_valid, r_err, r_mstart, r_mend;
  logic [OFF_W-1:0]     r_seg_off;
  logic [LEN_W-1:0]     r_seg_len;
  logic [DATA_W-1:0]    r_seg_data;

  function automatic logic [7:0] get_byte(input logic [DATA_W-1:0] d, input logic [LEN_W-1:0] k);
    logic [7:0] b;
    b = 8'h00;
    for (int i = 0; i < KEEP_W; i++)
      if (k == LEN_W'(i)) b = d[8*i +: 8];
    return b;
  endfunction

  function automatic logic [LEN_W-1:0] avail(input logic [LEN_W-1:0] e, input logic [LEN_W-1:0] p);
    return (e > p) ? e - p : '0;
  endfunction

  // A beat held with ready_o low is re-processed; its start_i must not restart the parse again.
  assign w_fresh = bus.valid_i && bus.start_i && !r_hold;
  assign w_e     = bus.last_i ? bus.last_len_i : LEN_W'(KEEP_W);

  always_comb begin
    w_st      = r_state;
    w_p       = r_off;
    w_rem     = r_rem;
    w_nhi     = r_hi;
    w_first   = r_pend;
    w_noff    = r_off;
    w_nhold   = r_hold;
    w_ready   = 1'b1;
    w_emit    = 1'b0;
    w_err     = 1'b0;
    w_mstart  = 1'b0;
    w_mend    = 1'b0;
    w_pay     = 1'b0;
    w_parsed  = 1'b0;
    w_avail   = '0;
    w_n       = '0;
    w_seg_off = '0;
    w_seg_len = '0;
    if (bus.valid_i) begin
      if (w_fresh) begin
        w_err   = (r_state != S_IDLE);
        w_st    = S_LEN;
        w_p     = LEN_W'(FIRST_OFF);
        w_first = 1'b0;
      end
      w_avail = avail(w_e, w_p);
      case (w_st)
        S_LEN: begin
          if (w_avail >= LEN_W'(2)) begin
            w_rem    = {get_byte(bus.data_i, w_p), get_byte(bus.data_i, w_p + LEN_W'(1))};
            w_p      = w_p + LEN_W'(2);
            w_pay    = 1'b1;
            w_parsed = 1'b1;
            w_first  = 1'b1;
          end else if (w_avail == LEN_W'(1)) begin
            w_nhi = get_byte(bus.data_i, w_p);
            w_p   = w_p + LEN_W'(1);
            w_st  = S_LEN_LO;
          end
        end
        S_LEN_LO: begin
          w_rem    = {r_hi, get_byte(bus.data_i, '0)};
          w_p      = LEN_W'(1);
          w_pay    = 1'b1;
          w_parsed = 1'b1;
          w_first  = 1'b1;
        end
        S_PAY:   w_pay = 1'b1;
        default: ;
      endcase
      if (w_pay) begin
        // Length ended exactly at the beat end: the start flag rides on the next beat's segment.
        if (w_parsed && w_p == w_e && w_rem != '0) begin
          w_st = S_PAY;
        end else begin
          w_avail   = avail(w_e, w_p);
          w_n       = (w_rem < MSG_LEN_W'(w_avail)) ? LEN_W'(w_rem) : w_avail;
          w_emit    = 1'b1;
          w_seg_off = w_p[OFF_W-1:0];
          w_seg_len = w_n;
          w_mstart  = w_first;
          w_mend    = (w_rem == MSG_LEN_W'(w_n));
          w_rem     = w_rem - MSG_LEN_W'(w_n);
          w_p       = w_p + w_n;
          w_first   = 1'b0;
          w_st      = w_mend ? S_LEN : S_PAY;
        end
      end
      if (w_st != S_IDLE && w_p < w_e) begin
        w_ready = 1'b0;
        w_noff  = w_p;
        w_nhold = 1'b1;
      end else begin
        w_noff  = '0;
        w_nhold = 1'b0;
        if (w_st != S_IDLE && bus.last_i) begin
          w_err = w_err || (w_st != S_LEN);
          w_st  = S_IDLE;
        end
      end
      if (w_st == S_IDLE) begin
        w_first = 1'b0;
        w_rem   = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r_state    <= S_IDLE;
      r_off      <= '0;
      r_rem      <= '0;
      r_hi       <= '0;
      r_pend     <= 1'b0;
      r_hold     <= 1'b0;
      r_valid    <= 1'b0;
      r_err      <= 1'b0;
      r_mstart   <= 1'b0;
      r_mend     <= 1'b0;
      r_seg_off  <= '0;
      r_seg_len  <= '0;
      r_seg_data <= '0;
    end else begin
      r_state  <= w_st;
      r_off    <= w_noff;
      r_rem    <= w_rem;
      r_hi     <= w_nhi;
      r_pend   <= w_first;
      r_hold   <= w_nhold;
      r_valid  <= w_emit;
      r_err    <= w_err;
      r_mstart <= w_emit && w_mstart;
      r_mend   <= w_emit && w_mend;
      if (w_emit) begin
        r_seg_off  <= w_seg_off;
        r_seg_len  <= w_seg_len;
        r_seg_data <= bus.data_i;
      end
    end
  end

  assign bus.ready_o     = w_ready;
  assign bus.valid_o     = r_valid;
  assign bus.err_o       = r_err;
  assign bus.msg_start_o = r_mstart;
  assign bus.msg_end_o   = r_mend;
  assign bus.seg_off_o   = r_seg_off;
  assign bus.seg_len_o   = r_seg_len;
  assign bus.seg_data_o  = r_seg_data;

`ifdef MSG_CNT_EN
  logic [MSG_LEN_W-1:0] r_cnt;

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset)
      r_cnt <= '0;
    else if (w_fresh)
      r_cnt <= (w_emit && w_mend) ? MSG_LEN_W'(1) : '0;
    else if (w_emit && w_mend && r_cnt != '1)
      r_cnt <= r_cnt + MSG_LEN_W'(1);
  end

  assign bus.msg_cnt_o = r_cnt;
`endif
endmodule
